// File: rtl/race_state_tracker.sv
// rtl/race_state_tracker.sv - race lifecycle controller: menu, countdown, running, finished
// Defining RACE_COUNTDOWN_EN inserts the countdown stage between menu and running.
module race_state_tracker #(
  parameter int NUM_PLAYERS  = 4,
  parameter int MAX_POS      = 109,
  parameter int COUNT_CYCLES = 1000,
  parameter int HOLD_CYCLES  = 5000,
  parameter int TIME_W       = 24,
  localparam int POS_W       = $clog2(MAX_POS),
  localparam int ID_W        = $clog2(NUM_PLAYERS),
  localparam int CD_W        = $clog2(COUNT_CYCLES + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         is_in_menu,
  input  logic [NUM_PLAYERS*POS_W-1:0] cur_pos,
  output logic                         game_started,
  output logic                         countdown_active,
  output logic [CD_W-1:0]              countdown_remaining,
  output logic                         go_pulse,
  output logic                         finished,
  output logic                         winner_valid,
  output logic [ID_W-1:0]              winner_id,
  output logic [TIME_W-1:0]            race_time,
  output logic                         menu_req
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [POS_W-1:0] FINISH_POS = POS_W'(MAX_POS - 1);

  typedef enum logic [1:0] {
    S_MENU      = 2'd0,
    S_COUNTDOWN = 2'd1,
    S_RUNNING   = 2'd2,
    S_FINISHED  = 2'd3
  } state_t;

  state_t            state;
  logic [HOLD_W-1:0] hold_cnt;
  logic              any_fin;
  logic [ID_W-1:0]   first_fin;

`ifdef RACE_COUNTDOWN_EN
  logic              cd_active;
  logic [CD_W-1:0]   cd_rem;
  assign countdown_active    = cd_active;
  assign countdown_remaining = cd_rem;
`else
  assign countdown_active    = 1'b0;
  assign countdown_remaining = '0;
`endif

  // Scan from the top so the lowest finishing index is the one left standing.
  always_comb begin
    any_fin   = 1'b0;
    first_fin = '0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (cur_pos[i*POS_W +: POS_W] >= FINISH_POS) begin
        any_fin   = 1'b1;
        first_fin = ID_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    go_pulse <= 1'b0;
    menu_req <= 1'b0;
    if (rst || is_in_menu) begin
      state        <= S_MENU;
      game_started <= 1'b0;
      finished     <= 1'b0;
      winner_valid <= 1'b0;
      winner_id    <= '0;
      race_time    <= '0;
      hold_cnt     <= '0;
`ifdef RACE_COUNTDOWN_EN
      cd_active    <= 1'b0;
      cd_rem       <= '0;
`endif
    end else begin
      case (state)
        S_MENU: begin
`ifdef RACE_COUNTDOWN_EN
          state     <= S_COUNTDOWN;
          cd_active <= 1'b1;
          cd_rem    <= CD_W'(COUNT_CYCLES);
`else
          state        <= S_RUNNING;
          game_started <= 1'b1;
          go_pulse     <= 1'b1;
          race_time    <= '0;
`endif
        end
`ifdef RACE_COUNTDOWN_EN
        S_COUNTDOWN: begin
          if (cd_rem == CD_W'(1)) begin
            state        <= S_RUNNING;
            cd_active    <= 1'b0;
            cd_rem       <= '0;
            game_started <= 1'b1;
            go_pulse     <= 1'b1;
            race_time    <= '0;
          end else begin
            cd_rem <= cd_rem - CD_W'(1);
          end
        end
`endif
        S_RUNNING: begin
          if (any_fin) begin
            state        <= S_FINISHED;
            game_started <= 1'b0;
            finished     <= 1'b1;
            winner_valid <= 1'b1;
            winner_id    <= first_fin;
            hold_cnt     <= HOLD_W'(HOLD_CYCLES);
          end else if (race_time != '1) begin
            race_time <= race_time + TIME_W'(1);
          end
        end
        S_FINISHED: begin
          // Counter parks at zero so the request fires only once per finish.
          if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
            menu_req <= (hold_cnt == HOLD_W'(1));
          end
        end
        default: state <= S_MENU;
      endcase
    end
  end

endmodule

// File: tb/tb_race_state_tracker.sv
// tb/tb_race_state_tracker.sv - directed and random checks of race_state_tracker against a phase model
module tb_race_state_tracker;

  localparam int NP    = 4;
  localparam int MP    = 109;
  localparam int CC    = 3;
  localparam int HC    = 4;
  localparam int TW    = 4;
  localparam int PW    = 7;
  localparam int IW    = 2;
  localparam int CW    = 2;
  localparam int FIN   = MP - 1;
  localparam int T_MAX = (1 << TW) - 1;
`ifdef RACE_COUNTDOWN_EN
  localparam bit CD_EN = 1'b1;
`else
  localparam bit CD_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          is_in_menu;
  logic [NP*PW-1:0] cur_pos;
  logic          game_started;
  logic          countdown_active;
  logic [CW-1:0] countdown_remaining;
  logic          go_pulse;
  logic          finished;
  logic          winner_valid;
  logic [IW-1:0] winner_id;
  logic [TW-1:0] race_time;
  logic          menu_req;

  race_state_tracker #(
    .NUM_PLAYERS(NP), .MAX_POS(MP), .COUNT_CYCLES(CC), .HOLD_CYCLES(HC), .TIME_W(TW)
  ) dut (
    .clk(clk), .rst(rst), .is_in_menu(is_in_menu), .cur_pos(cur_pos),
    .game_started(game_started), .countdown_active(countdown_active),
    .countdown_remaining(countdown_remaining), .go_pulse(go_pulse),
    .finished(finished), .winner_valid(winner_valid), .winner_id(winner_id),
    .race_time(race_time), .menu_req(menu_req)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pos [NP];

  // Reference model: race phase plus elapsed-cycle counts
  typedef enum {P_MENU, P_CD, P_RUN, P_FIN} phase_t;
  phase_t ph = P_MENU;
  int cd_left = 0, run_cycles = 0, fin_age = 0, win = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive_pos();
    for (int i = 0; i < NP; i++) cur_pos[i*PW +: PW] = pos[i][PW-1:0];
  endtask

  task automatic set_all_pos(input int v);
    for (int i = 0; i < NP; i++) pos[i] = v;
    drive_pos();
  endtask

  task automatic model_step();
    if (rst || is_in_menu) begin
      ph = P_MENU; cd_left = 0; run_cycles = 0; fin_age = 0; win = 0;
    end else begin
      case (ph)
        P_MENU: if (CD_EN) begin ph = P_CD; cd_left = CC; end
                else begin ph = P_RUN; run_cycles = 0; end
        P_CD:   if (cd_left == 1) begin ph = P_RUN; run_cycles = 0; end
                else cd_left--;
        P_RUN: begin
          win = -1;
          for (int i = NP - 1; i >= 0; i--) if (pos[i] >= FIN) win = i;
          if (win >= 0) begin ph = P_FIN; fin_age = 0; end
          else run_cycles++;
        end
        P_FIN: fin_age++;
      endcase
    end
  endtask

  task automatic check_all(input string ctx);
    int rt;
    rt = (ph == P_RUN || ph == P_FIN) ? ((run_cycles > T_MAX) ? T_MAX : run_cycles) : 0;
    chk({ctx, ".game_started"},     game_started,        ph == P_RUN);
    chk({ctx, ".countdown_active"}, countdown_active,    ph == P_CD);
    chk({ctx, ".countdown_rem"},    countdown_remaining, (ph == P_CD) ? cd_left : 0);
    chk({ctx, ".go_pulse"},         go_pulse,            ph == P_RUN && run_cycles == 0);
    chk({ctx, ".finished"},         finished,            ph == P_FIN);
    chk({ctx, ".winner_valid"},     winner_valid,        ph == P_FIN);
    chk({ctx, ".winner_id"},        winner_id,           (ph == P_FIN) ? win : 0);
    chk({ctx, ".race_time"},        race_time,           rt);
    chk({ctx, ".menu_req"},         menu_req,            ph == P_FIN && fin_age == HC);
  endtask

  task automatic step(input string ctx);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all(ctx);
  endtask

  task automatic start_race(input string ctx);
    is_in_menu = 1'b0;
    step(ctx);
`ifdef RACE_COUNTDOWN_EN
    for (int i = 0; i < CC; i++) step(ctx);
`endif
  endtask

  initial begin
    rst = 1'b1;
    is_in_menu = 1'b0;
    set_all_pos(0);
    @(negedge clk);

    // reset holds everything at zero
    step("rst0");
    step("rst1");
    chk("rst_game_started", game_started, 0);
    chk("rst_winner_valid", winner_valid, 0);
    chk("rst_race_time", race_time, 0);
    rst = 1'b0;

    // release: countdown (if present) then running with a go pulse
`ifdef RACE_COUNTDOWN_EN
    step("cd");
    chk("cd_active", countdown_active, 1);
    chk("cd_rem3", countdown_remaining, 3);
    step("cd");
    chk("cd_rem2", countdown_remaining, 2);
    step("cd");
    chk("cd_rem1", countdown_remaining, 1);
`endif
    step("go");
    chk("go_pulse_on", go_pulse, 1);
    chk("go_started", game_started, 1);
    chk("go_cd_off", countdown_active, 0);
    for (int i = 0; i < 5; i++) step("run_a");
    chk("go_pulse_off", go_pulse, 0);
    chk("run_a_time", race_time, 5);

    // players 1 and 3 cross together: lowest index wins, time frozen
    pos[1] = FIN; pos[3] = FIN; drive_pos();
    step("fin_a");
    chk("fin_a_finished", finished, 1);
    chk("fin_a_winner", winner_id, 1);
    chk("fin_a_valid", winner_valid, 1);
    chk("fin_a_time", race_time, 5);
    for (int i = 0; i < 3; i++) step("hold");
    chk("hold_early", menu_req, 0);
    step("hold");
    chk("hold_pulse", menu_req, 1);
    for (int i = 0; i < 6; i++) step("hold_after");
    chk("hold_no_repeat", menu_req, 0);
    chk("hold_still_fin", finished, 1);
    is_in_menu = 1'b1;
    step("to_menu");
    chk("menu_winner_cleared", winner_valid, 0);
    chk("menu_finished_off", finished, 0);

    // long race saturates the timer, then menu aborts it
    set_all_pos(0);
    start_race("run_b_start");
    for (int i = 0; i < 20; i++) step("run_b");
    chk("run_b_saturate", race_time, T_MAX);
    is_in_menu = 1'b1;
    step("abort_b");
    chk("abort_b_time", race_time, 0);
    chk("abort_b_started", game_started, 0);

    // finishers already present at race start
    pos[2] = FIN; pos[3] = 127; drive_pos();
    start_race("run_c_start");
    chk("run_c_go", go_pulse, 1);
    step("fin_c");
    chk("fin_c_winner", winner_id, 2);
    chk("fin_c_time", race_time, 0);

    // reset mid-race
    is_in_menu = 1'b1;
    set_all_pos(0);
    step("menu_d");
    start_race("run_d_start");
    for (int i = 0; i < 3; i++) step("run_d");
    rst = 1'b1;
    step("rst_d");
    chk("rst_d_go", go_pulse, 0);
    chk("rst_d_time", race_time, 0);
    rst = 1'b0;

    // random traffic against the model
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(0, 149) == 0);
      is_in_menu = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < NP; i++)
        pos[i] = ($urandom_range(0, 59) == 0) ? int'($urandom_range(FIN, 127))
                                              : int'($urandom_range(0, FIN - 1));
      drive_pos();
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
